// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: two result producers, register file write port and
// the forwarding view of the held entry.
interface writeback_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic [REG_ADDR_W-1:0] write_register;
    logic [XLEN-1:0]       write_data;
    logic                  write_data_valid;
    logic                  write_valid;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]       fwd_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output write_register, write_data, write_data_valid,
        input  write_valid,
        output fwd_valid, fwd_rd, fwd_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  write_register, write_data, write_data_valid,
        output write_valid,
        input  fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter between ALU and LSU results with a
// one-entry output register feeding the register file and bypass network.
module writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic               clk,
    input logic               rst,
    writeback_arbiter_if.slave wb
);
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    logic                  out_valid;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [XLEN-1:0]       out_data;
    src_e                  last_grant;

    logic                  nxt_valid;
    logic [REG_ADDR_W-1:0] nxt_rd;
    logic [XLEN-1:0]       nxt_data;
    src_e                  nxt_grant;

    logic                  free;
    logic                  gnt_alu;
    logic                  gnt_mem;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_rd     <= '0;
            out_data   <= '0;
            last_grant <= SRC_MEM;
        end else begin
            out_valid  <= nxt_valid;
            out_rd     <= nxt_rd;
            out_data   <= nxt_data;
            last_grant <= nxt_grant;
        end
    end

    always_comb begin
        free    = !out_valid || wb.write_valid;
        gnt_alu = free && wb.alu_valid &&
                  (!wb.mem_valid || last_grant == SRC_MEM);
        gnt_mem = free && wb.mem_valid && !gnt_alu;

        sel_rd   = gnt_alu ? wb.alu_rd : wb.mem_rd;
        sel_data = gnt_alu ? wb.alu_data : wb.mem_data;
        // x0 results are consumed but never occupy the output register
        load     = (gnt_alu || gnt_mem) && (sel_rd != '0);

        nxt_valid = out_valid;
        nxt_rd    = out_rd;
        nxt_data  = out_data;
        nxt_grant = last_grant;

        unique case (1'b1)
            gnt_alu: nxt_grant = SRC_ALU;
            gnt_mem: nxt_grant = SRC_MEM;
            default: nxt_grant = last_grant;
        endcase

        if (load) begin
            nxt_valid = 1'b1;
            nxt_rd    = sel_rd;
            nxt_data  = sel_data;
        end else if (out_valid && wb.write_valid) begin
            nxt_valid = 1'b0;
        end
    end

    // Readies are masked by reset so every output reads 0 while held in reset
    always_comb begin
        wb.alu_ready        = gnt_alu && rst;
        wb.mem_ready        = gnt_mem && rst;
        wb.write_data_valid = out_valid;
        wb.write_register   = out_rd;
        wb.write_data       = out_data;
        wb.fwd_valid        = out_valid;
        wb.fwd_rd           = out_rd;
        wb.fwd_data         = out_data;
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, arbitration, stall,
// x0 drop and an end-to-end stream into a register file model.
module tb_writeback_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] rf [32];

    writeback_arbiter_if #(.XLEN(32), .REG_ADDR_W(5)) wb ();

    writeback_arbiter #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: writes every requested index, reg0 included
    always @(posedge clk) begin
        if (wb.write_data_valid && wb.write_valid)
            rf[wb.write_register] <= wb.write_data;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v,
                             input logic [4:0] rd, input logic [31:0] d);
        check({tag, ".wdv"}, 64'(wb.write_data_valid), 64'(v));
        check({tag, ".wreg"}, 64'(wb.write_register), 64'(rd));
        check({tag, ".wdata"}, 64'(wb.write_data), 64'(d));
        check({tag, ".fwdv"}, 64'(wb.fwd_valid), 64'(v));
        check({tag, ".fwdrd"}, 64'(wb.fwd_rd), 64'(rd));
        check({tag, ".fwdd"}, 64'(wb.fwd_data), 64'(d));
    endtask

    task automatic check_rdy(input string tag, input logic a, input logic m);
        check({tag, ".alu_rdy"}, 64'(wb.alu_ready), 64'(a));
        check({tag, ".mem_rdy"}, 64'(wb.mem_ready), 64'(m));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst = 1'b0;
        wb.alu_valid   = 1'b0;
        wb.alu_rd      = '0;
        wb.alu_data    = '0;
        wb.mem_valid   = 1'b0;
        wb.mem_rd      = '0;
        wb.mem_data    = '0;
        wb.write_valid = 1'b0;
        #3;
        check_out("rst", 1'b0, 5'd0, 32'h0);
        wb.alu_valid = 1'b1;
        #1;
        check_rdy("rst", 1'b0, 1'b0);
        wb.alu_valid = 1'b0;
        tick();
        rst = 1'b1;

        // single ALU result
        wb.write_valid = 1'b1;
        wb.alu_valid   = 1'b1;
        wb.alu_rd      = 5'd1;
        wb.alu_data    = 32'hdead_beef;
        #1;
        check_rdy("single", 1'b1, 1'b0);
        tick();
        wb.alu_valid = 1'b0;
        #1;
        check_out("single", 1'b1, 5'd1, 32'hdead_beef);
        tick();
        check("single.idle", 64'(wb.write_data_valid), 64'd0);

        // contention after a fresh reset: ALU first, then alternate
        rst = 1'b0;
        #1;
        rst = 1'b1;
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd2;
        wb.alu_data  = 32'h1111_1111;
        wb.mem_valid = 1'b1;
        wb.mem_rd    = 5'd3;
        wb.mem_data  = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_rdy($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            if (i % 2 == 0) check_out($sformatf("cont%0d", i), 1'b1, 5'd2,
                                      32'h1111_1111);
            else check_out($sformatf("cont%0d", i), 1'b1, 5'd3,
                           32'h2222_2222);
        end
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
        tick();
        check("cont.idle", 64'(wb.write_data_valid), 64'd0);

        // stall: entry held three cycles, next result loads on release
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd5;
        wb.alu_data  = 32'haabb_ccdd;
        tick();
        wb.write_valid = 1'b0;
        wb.alu_rd      = 5'd6;
        wb.alu_data    = 32'h6666_6666;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_out($sformatf("stall%0d", i), 1'b1, 5'd5, 32'haabb_ccdd);
            check_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
            tick();
        end
        wb.write_valid = 1'b1;
        #1;
        check_rdy("release", 1'b1, 1'b0);
        tick();
        wb.alu_valid = 1'b0;
        check_out("release", 1'b1, 5'd6, 32'h6666_6666);

        // x0 drop: accepted, no write, last_grant moves to MEM
        wb.mem_valid = 1'b1;
        wb.mem_rd    = 5'd0;
        wb.mem_data  = 32'hffff_ffff;
        #1;
        check_rdy("x0", 1'b0, 1'b1);
        tick();
        wb.mem_valid = 1'b0;
        #1;
        check("x0.wdv", 64'(wb.write_data_valid), 64'd0);
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd7;
        wb.alu_data  = 32'h7777_7777;
        wb.mem_valid = 1'b1;
        wb.mem_rd    = 5'd8;
        wb.mem_data  = 32'h8888_8888;
        #1;
        check_rdy("x0.tie", 1'b1, 1'b0);
        tick();
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
        check_out("x0.tie", 1'b1, 5'd7, 32'h7777_7777);
        tick();

        // reset mid-stall drops the pending entry
        wb.write_valid = 1'b0;
        wb.alu_valid   = 1'b1;
        wb.alu_rd      = 5'd9;
        wb.alu_data    = 32'h9999_9999;
        tick();
        check("rst2.pre", 64'(wb.write_data_valid), 64'd1);
        rst = 1'b0;
        #1;
        check_out("rst2", 1'b0, 5'd0, 32'h0);
        check_rdy("rst2", 1'b0, 1'b0);
        wb.alu_valid = 1'b0;
        tick();
        rst = 1'b1;
        wb.write_valid = 1'b1;
        tick();
        check("rst2.gone", 64'(wb.write_data_valid), 64'd0);

        // end-to-end stream of 8 results into the register file
        for (int i = 1; i <= 8; i++) begin
            wb.alu_valid = 1'b1;
            wb.alu_rd    = 5'(i);
            wb.alu_data  = 32'h0a0b_0000 | 32'(i);
            tick();
        end
        wb.alu_valid = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++)
            check($sformatf("rf%0d", i), 64'(rf[i]),
                  64'(32'h0a0b_0000 | 32'(i)));
        check("rf0", 64'(rf[0]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
